// File: rtl/spram_fifo_ctrl.sv
// FIFO controller that time-shares one external single-port RAM between a
// valid/ready write stream and a registered valid/ready read stream.
module spram_fifo_ctrl #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic             ram_we,
  output logic [DEPTH-1:0] ram_addr,
  output logic [WIDTH-1:0] ram_data,
  input  logic [WIDTH-1:0] ram_q,
  output logic [DEPTH:0]   count,
  output logic             full,
  output logic             empty
);

  localparam int unsigned CAP = 1 << DEPTH;

  typedef enum logic [1:0] {IDLE, RD_WAIT, HOLD} state_t;

  state_t           state;
  state_t           state_nxt;
  logic [DEPTH-1:0] wr_ptr;
  logic [DEPTH-1:0] rd_ptr;
  logic             rd_issue;
  logic             wr_fire;
  logic             has_data;

  assign has_data = (count != '0);
  assign full     = (count == (DEPTH+1)'(CAP));
  assign empty    = !has_data && !out_valid;

  // Next state and read issue; a read beats a write for the shared port.
  always_comb begin
    state_nxt = state;
    rd_issue  = 1'b0;
    case (state)
      IDLE: begin
        if (has_data) begin
          rd_issue  = 1'b1;
          state_nxt = RD_WAIT;
        end
      end
      RD_WAIT: state_nxt = HOLD;
      HOLD: begin
        if (out_ready) begin
          if (has_data) begin
            rd_issue  = 1'b1;
            state_nxt = RD_WAIT;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // RAM port sharing and write handshake.
  always_comb begin
    in_ready = !full && !rd_issue;
    wr_fire  = in_valid && in_ready;
    ram_we   = wr_fire;
    ram_addr = rd_issue ? rd_ptr : wr_ptr;
    ram_data = in_data;
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Pointers and occupancy; count may rise and fall on the same edge.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_fire) begin
        wr_ptr <= wr_ptr + DEPTH'(1);
      end
      if (rd_issue) begin
        rd_ptr <= rd_ptr + DEPTH'(1);
      end
      count <= count + (DEPTH+1)'(wr_fire) - (DEPTH+1)'(rd_issue);
    end
  end

  // Output register: loaded from ram_q the cycle after a read issue.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      out_data  <= '0;
    end else if (state == RD_WAIT) begin
      out_valid <= 1'b1;
      out_data  <= ram_q;
    end else if (state == HOLD && out_ready) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_spram_fifo_ctrl.sv
// Self-checking bench for spram_fifo_ctrl: queue-based reference model,
// per-cycle output compare, and directed plus random stimulus.
module tb_spram_fifo_ctrl;

  logic       clock = 1'b0;
  logic       reset_n = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic [7:0] in_data = 8'h00;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic [7:0] out_data;
  logic       ram_we;
  logic [3:0] ram_addr;
  logic [7:0] ram_data;
  logic [7:0] ram_q;
  logic [4:0] count;
  logic       full;
  logic       empty;

  int checks = 0;
  int errors = 0;

  spram_fifo_ctrl #(.WIDTH(8), .DEPTH(4)) dut (
    .clock(clock), .reset_n(reset_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .ram_we(ram_we), .ram_addr(ram_addr), .ram_data(ram_data), .ram_q(ram_q),
    .count(count), .full(full), .empty(empty)
  );

  always #5 clock = ~clock;

  // External single-port RAM with registered read data.
  logic [7:0] mem [16];
  always @(posedge clock) begin
    if (ram_we) mem[ram_addr] <= ram_data;
    ram_q <= mem[ram_addr];
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: entries stored in RAM, one read in flight, one held output.
  logic [7:0] mq [$];
  bit         pend = 1'b0;
  logic [7:0] pd = 8'h00;
  bit         hv = 1'b0;
  logic [7:0] hd = 8'h00;
  int         wr_total = 0;
  int         rd_total = 0;
  logic [7:0] got [$];

  function automatic bit m_issue();
    return (mq.size() != 0) && ((!pend && !hv) || (hv && out_ready));
  endfunction

  function automatic bit m_in_ready();
    return (mq.size() < 16) && !m_issue();
  endfunction

  always @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      mq.delete();
      pend = 1'b0; hv = 1'b0; hd = 8'h00; pd = 8'h00;
      wr_total = 0; rd_total = 0;
    end else begin
      bit iss, psh;
      iss = m_issue();
      psh = in_valid && m_in_ready();
      if (hv && out_ready) hv = 1'b0;
      if (pend) begin hv = 1'b1; hd = pd; pend = 1'b0; end
      if (iss) begin pend = 1'b1; pd = mq.pop_front(); rd_total++; end
      if (psh) begin mq.push_back(in_data); wr_total++; end
    end
  end

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clock) begin
    bit iss, rdy;
    iss = m_issue();
    rdy = m_in_ready();
    chk("out_valid", 32'(out_valid), 32'(hv));
    chk("out_data",  32'(out_data),  32'(hd));
    chk("count",     32'(count),     32'(mq.size()));
    chk("full",      32'(full),      32'(mq.size() == 16));
    chk("empty",     32'(empty),     32'(mq.size() == 0 && !hv));
    chk("in_ready",  32'(in_ready),  32'(rdy));
    chk("ram_we",    32'(ram_we),    32'(in_valid && rdy));
    chk("ram_addr",  32'(ram_addr),  32'(iss ? (rd_total % 16) : (wr_total % 16)));
    chk("ram_data",  32'(ram_data),  32'(in_data));
    if (reset_n && out_valid && out_ready) got.push_back(out_data);
  end

  int stall_cycles;

  task automatic do_reset();
    @(posedge clock); #1;
    reset_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    repeat (2) @(posedge clock);
    #1 reset_n = 1'b1;
  endtask

  // Call at posedge+1; returns at posedge+1 after the accepting edge.
  task automatic push(input logic [7:0] d);
    bit acc;
    acc = 1'b0;
    in_valid = 1'b1; in_data = d;
    for (int i = 0; i < 200; i++) begin
      @(negedge clock); #1;
      if (in_ready) begin acc = 1'b1; break; end
      stall_cycles++;
    end
    chk("push_accept_timeout", 32'(acc), 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0;
  endtask

  task automatic wait_got(input int n, input int budget);
    for (int i = 0; i < budget && got.size() < n; i++) begin
      @(negedge clock); #1;
    end
    chk("drain_count", 32'(got.size()), 32'(n));
    @(posedge clock); #1;
  endtask

  initial begin
    logic [7:0] exp [$];
    int sent;
    #2_000_000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] exp [$];
    int sent;

    // T1: reset state, collision stall, first-item latency
    do_reset();
    @(negedge clock); #1;
    chk("t1_reset_count", 32'(count), 32'd0);
    chk("t1_reset_empty", 32'(empty), 32'd1);
    chk("t1_reset_valid", 32'(out_valid), 32'd0);
    @(posedge clock); #1;
    stall_cycles = 0;
    push(8'h11); push(8'h22); push(8'h33);
    chk("t1_stall_cycles", 32'(stall_cycles), 32'd1);
    @(negedge clock); #1;
    chk("t1_out_valid", 32'(out_valid), 32'd1);
    chk("t1_out_data", 32'(out_data), 32'h11);
    chk("t1_count", 32'(count), 32'd2);

    // T2: fill to capacity, backpressure, ordered drain
    do_reset();
    for (int i = 0; i < 17; i++) push(8'(i));
    @(negedge clock); #1;
    chk("t2_full", 32'(full), 32'd1);
    chk("t2_count", 32'(count), 32'd16);
    chk("t2_in_ready", 32'(in_ready), 32'd0);
    @(posedge clock); #1;
    in_valid = 1'b1; in_data = 8'h99;
    repeat (3) begin
      @(negedge clock); #1;
      chk("t2_held_off", 32'(in_ready), 32'd0);
    end
    @(posedge clock); #1;
    in_valid = 1'b0;
    got.delete();
    out_ready = 1'b1;
    wait_got(17, 200);
    out_ready = 1'b0;
    for (int i = 0; i < 17 && i < got.size(); i++) chk("t2_order", 32'(got[i]), 32'(i));
    @(negedge clock); #1;
    chk("t2_empty", 32'(empty), 32'd1);
    @(posedge clock); #1;

    // T3: continuous stream with pointer wrap
    do_reset();
    got.delete();
    out_ready = 1'b1;
    for (int i = 0; i < 40; i++) push(8'(i));
    wait_got(40, 200);
    out_ready = 1'b0;
    for (int i = 0; i < 40 && i < got.size(); i++) chk("t3_order", 32'(got[i]), 32'(i));

    // T4: random handshakes on both sides
    do_reset();
    got.delete();
    sent = 0;
    for (int cyc = 0; cyc < 20000 && got.size() < 1000; cyc++) begin
      in_valid  = (sent < 1000) && ($urandom_range(0, 1) == 1);
      in_data   = 8'($urandom);
      out_ready = ($urandom_range(0, 1) == 1);
      @(negedge clock); #1;
      if (in_valid && in_ready) begin exp.push_back(in_data); sent++; end
      @(posedge clock); #1;
    end
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t4_items", 32'(got.size()), 32'd1000);
    for (int i = 0; i < got.size() && i < exp.size(); i++) chk("t4_scoreboard", 32'(got[i]), 32'(exp[i]));

    // T5: asynchronous reset while a read is in flight
    do_reset();
    for (int i = 0; i < 7; i++) push(8'h40 + 8'(i));
    out_ready = 1'b1;
    @(posedge clock); #1;
    out_ready = 1'b0;
    chk("t5_count_before", 32'(count), 32'd5);
    #2 reset_n = 1'b0;
    #1;
    chk("t5_async_valid", 32'(out_valid), 32'd0);
    chk("t5_async_count", 32'(count), 32'd0);
    chk("t5_async_empty", 32'(empty), 32'd1);
    @(posedge clock); #1;
    reset_n = 1'b1;
    got.delete();
    push(8'hA5);
    out_ready = 1'b1;
    wait_got(1, 20);
    out_ready = 1'b0;
    if (got.size() > 0) chk("t5_first_item", 32'(got[0]), 32'hA5);

    // T6: pop from HOLD with empty RAM while a write arrives
    do_reset();
    push(8'h01);
    begin
      bit seen;
      seen = 1'b0;
      for (int i = 0; i < 20; i++) begin
        @(negedge clock); #1;
        if (out_valid) begin seen = 1'b1; break; end
      end
      chk("t6_hold_reached", 32'(seen), 32'd1);
    end
    chk("t6_hold_count", 32'(count), 32'd0);
    out_ready = 1'b1; in_valid = 1'b1; in_data = 8'h5A;
    #1 chk("t6_in_ready", 32'(in_ready), 32'd1);
    @(posedge clock); #1;
    in_valid = 1'b0; out_ready = 1'b0;
    chk("t6_after_pop_valid", 32'(out_valid), 32'd0);
    chk("t6_after_pop_count", 32'(count), 32'd1);
    repeat (2) @(posedge clock);
    #1;
    chk("t6_readback_valid", 32'(out_valid), 32'd1);
    chk("t6_readback_data", 32'(out_data), 32'h5A);

    @(posedge clock); #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
